mod_n_updown_fsm: RTL and testbench
===================================

Name: mod_n_updown_fsm

Overview:
Parametrised modulo-N counter FSM that generalises the fixed 0-to-7 sequencer. It supports configurable width and modulus, runtime up/down/ping-pong/hold modes, clock enable, synchronous parallel load and terminal-count flags. It serves as the general sequencing and timing counter for the lab designs (display scanners, sequencers, dividers).

Parameters:
WIDTH, 4, bit width of count; must satisfy 2**WIDTH >= MODULO
MODULO, 8, number of states; count range 0..MODULO-1; MODULO >= 2

Ports:
clk  input  1  rising-edge clock
re  input  1  asynchronous active-high reset
en  input  1  count enable; steps the counter one position per clk when high
mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold
load  input  1  synchronous load strobe
load_val  input  WIDTH  value loaded when load=1
count  output  WIDTH  current count (registered)
tc  output  1  terminal count; combinational from registered state
wrap  output  1  registered one-cycle pulse after a wrap or turn-around step

Behaviour:
- One clock; reset is asynchronous and active-high on re.
- Reset: count=0, direction state=PP_UP, wrap=0. tc then follows its rule for count=0.
- Priority per clk edge: re > load > en > hold.
- Load (load=1):
  - count <= load_val when load_val <= MODULO-1, else count <= MODULO-1 (clamp).
  - wrap <= 0.
  - Direction state <= PP_UP, except load to MODULO-1 in ping-pong mode sets PP_DOWN.
  - en is ignored in a load cycle.
- Step (en=1, load=0), by mode:
  - Up: count+1; at MODULO-1, wraps to 0 and wrap pulses.
  - Down: count-1; at 0, wraps to MODULO-1 and wrap pulses.
  - Ping-pong: 2-state direction FSM.
    - PP_UP: count+1. At MODULO-1, count <= MODULO-2, state -> PP_DOWN, wrap pulses.
    - PP_DOWN: count-1. At 0, count <= 1, state -> PP_UP, wrap pulses.
    - MODULO=2 toggles 0,1,0,1 with wrap on every step.
  - Hold: count unchanged, wrap=0.
- en=0: count and direction state unchanged; wrap <= 0.
- Direction state is forced to PP_UP whenever mode != 10, so entering ping-pong always starts upward. If count=MODULO-1 on entry, the first step turns down (to MODULO-2) with a wrap pulse.
- tc, combinational:
  - Up: count==MODULO-1.
  - Down: count==0.
  - Ping-pong: (PP_UP and count==MODULO-1) or (PP_DOWN and count==0).
  - Hold: 0.
  - tc is independent of en.
- wrap is high exactly one cycle, in the cycle after the step that wrapped or turned around.
- Mode change mid-count takes effect on the next enabled step. No count glitch; count is always a register output.
- All arithmetic is WIDTH bits wide. Out-of-range values (>= MODULO) are unreachable except via reset/load, and load clamps.
- re asserted mid-operation immediately forces reset values, independent of clk.

Optional Feature:
GRAY_OUT_EN
- Defined: adds output count_gray (WIDTH bits), registered, equal to count ^ (count>>1). It updates in the same edge as count and resets to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package mod_n_pkg: mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PINGPONG=2'b10, MODE_HOLD=2'b11, and direction state encodings PP_UP=1'b0, PP_DOWN=1'b1.
- Sub-module bin2gray (parameter WIDTH, combinational) instantiated only under GRAY_OUT_EN. Registering stays in the parent.

Test Plan:
- Defaults, re pulse then en=1 mode=00 for 10 clks -> count 0..7,0,1; tc high at 7; wrap high the cycle count reads 0.
- mode=01 from reset, en=1 -> count 0,7,6,5; tc high at 0; wrap pulse after 0->7.
- MODULO=5, mode=10, en=1 for 12 clks -> 0,1,2,3,4,3,2,1,0,1,2,3; tc at 4 (PP_UP) and 0 (PP_DOWN); wrap after each turn.
- load=1 load_val=12 with MODULO=8 and en=1 in the same cycle -> count=7, en ignored; next en step in up mode -> 0 with wrap.
- en toggling 1,0,0,1 in mode=00; then mode=11 with en=1 -> count advances only on en=1 cycles; holds in mode 11 with tc=0.
- re asserted asynchronously between clk edges at count=5 -> count=0 immediately, wrap=0; with GRAY_OUT_EN, count_gray=0, and counting 0..7 gives gray 0,1,3,2,6,7,5,4.

Source files
------------

// File: rtl/mod_n_pkg.sv
// Shared encodings for the modulo-N up/down/ping-pong counter.
package mod_n_pkg;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_PINGPONG = 2'b10;
    localparam logic [1:0] MODE_HOLD     = 2'b11;

    typedef enum logic {
        PP_UP   = 1'b0,
        PP_DOWN = 1'b1
    } pp_dir_e;

endpackage

// File: rtl/mod_n_updown_fsm_bin2gray.sv
// Combinational binary-to-Gray converter used for the optional Gray count output.
module bin2gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/mod_n_updown_fsm.sv
// Modulo-N counter with up/down/ping-pong/hold modes, load, tc and wrap flags.
// Define GRAY_OUT_EN to add the registered count_gray output.
module mod_n_updown_fsm
    import mod_n_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 8
) (
    input  logic             clk,
    input  logic             re,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
`ifdef GRAY_OUT_EN
    output logic [WIDTH-1:0] count_gray,
`endif
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] TURN_DN  = WIDTH'(MODULO - 2);
    localparam logic [WIDTH-1:0] ZERO_VAL = '0;
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_q, wrap_d;
    pp_dir_e          dir_q, dir_d;

    always_ff @(posedge clk or posedge re) begin
        if (re) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            dir_q   <= PP_UP;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            dir_q   <= dir_d;
        end
    end

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_clamped;
            dir_d   = (mode == MODE_PINGPONG && load_clamped == MAX_VAL) ? PP_DOWN : PP_UP;
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    if (count_q == MAX_VAL) begin
                        count_d = ZERO_VAL;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + ONE_VAL;
                    end
                end
                MODE_DOWN: begin
                    if (count_q == ZERO_VAL) begin
                        count_d = MAX_VAL;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - ONE_VAL;
                    end
                end
                MODE_PINGPONG: begin
                    // A turn-around step moves away from the end point rather than dwelling on it.
                    if (dir_q == PP_UP) begin
                        if (count_q == MAX_VAL) begin
                            count_d = TURN_DN;
                            dir_d   = PP_DOWN;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q + ONE_VAL;
                        end
                    end else begin
                        if (count_q == ZERO_VAL) begin
                            count_d = ONE_VAL;
                            dir_d   = PP_UP;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_q - ONE_VAL;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Leaving ping-pong resets the direction so re-entry always starts upward.
        if (mode != MODE_PINGPONG) begin
            dir_d = PP_UP;
        end
    end

    always_comb begin
        tc = 1'b0;
        case (mode)
            MODE_UP:       tc = (count_q == MAX_VAL);
            MODE_DOWN:     tc = (count_q == ZERO_VAL);
            MODE_PINGPONG: tc = (dir_q == PP_UP)   ? (count_q == MAX_VAL)
                                                   : (count_q == ZERO_VAL);
            default:       tc = 1'b0;
        endcase
    end

    assign count = count_q;
    assign wrap  = wrap_q;

`ifdef GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q, gray_d;

    bin2gray #(.WIDTH(WIDTH)) u_bin2gray (
        .bin_i  (count_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk or posedge re) begin
        if (re) begin
            gray_q <= '0;
        end else begin
            gray_q <= gray_d;
        end
    end

    assign count_gray = gray_q;
`endif

endmodule

// File: tb/tb_mod_n_updown_fsm.sv
// Directed scoreboard bench: one default counter (MODULO=8) and one MODULO=5 counter.
module tb_mod_n_updown_fsm;
    import mod_n_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=4, MODULO=8
    logic       re_a, en_a, load_a, tc_a, wrap_a;
    logic [1:0] mode_a;
    logic [3:0] lv_a, count_a;
    // DUT B: WIDTH=3, MODULO=5
    logic       re_b, en_b, load_b, tc_b, wrap_b;
    logic [1:0] mode_b;
    logic [2:0] lv_b, count_b;
`ifdef GRAY_OUT_EN
    logic [3:0] gray_a;
    logic [2:0] gray_b;
`endif

    mod_n_updown_fsm #(.WIDTH(4), .MODULO(8)) dut_a (
        .clk(clk), .re(re_a), .en(en_a), .mode(mode_a), .load(load_a),
        .load_val(lv_a), .count(count_a), .tc(tc_a),
`ifdef GRAY_OUT_EN
        .count_gray(gray_a),
`endif
        .wrap(wrap_a)
    );

    mod_n_updown_fsm #(.WIDTH(3), .MODULO(5)) dut_b (
        .clk(clk), .re(re_b), .en(en_b), .mode(mode_b), .load(load_b),
        .load_val(lv_b), .count(count_b), .tc(tc_b),
`ifdef GRAY_OUT_EN
        .count_gray(gray_b),
`endif
        .wrap(wrap_b)
    );

    typedef struct {
        string tag;
        bit    on_b;
        int    cnt;
        bit    tc;
        bit    wrap;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        e = sb.pop_front();
        if (e.on_b) begin
            check({e.tag, ".count"}, {29'd0, count_b}, e.cnt);
            check({e.tag, ".tc"},    {31'd0, tc_b},    {31'd0, e.tc});
            check({e.tag, ".wrap"},  {31'd0, wrap_b},  {31'd0, e.wrap});
        end else begin
            check({e.tag, ".count"}, {28'd0, count_a}, e.cnt);
            check({e.tag, ".tc"},    {31'd0, tc_a},    {31'd0, e.tc});
            check({e.tag, ".wrap"},  {31'd0, wrap_a},  {31'd0, e.wrap});
        end
        $display("txn %s dut=%s count_a=%0d count_b=%0d exp_count=%0d", e.tag,
                 e.on_b ? "B" : "A", count_a, count_b, e.cnt);
    endtask

    // Drive one cycle on DUT A, push the expectation, then compare after the edge.
    task automatic step_a(input string tag, input bit en, input logic [1:0] mode,
                          input bit load, input logic [3:0] lv,
                          input int ecnt, input bit etc, input bit ewrap);
        en_a = en; mode_a = mode; load_a = load; lv_a = lv;
        sb.push_back('{tag, 1'b0, ecnt, etc, ewrap});
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic step_b(input string tag, input bit en, input logic [1:0] mode,
                          input int ecnt, input bit etc, input bit ewrap);
        en_b = en; mode_b = mode; load_b = 1'b0; lv_b = 3'd0;
        sb.push_back('{tag, 1'b1, ecnt, etc, ewrap});
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic reset_a();
        en_a = 1'b0; load_a = 1'b0; mode_a = MODE_UP; lv_a = 4'd0;
        re_a = 1'b1;
        #2;
        check("rst_a.count", {28'd0, count_a}, 0);
        check("rst_a.wrap",  {31'd0, wrap_a},  0);
        re_a = 1'b0;
    endtask

    int pp_cnt[11]  = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3};
    bit pp_tc[11]   = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    bit pp_wrap[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

    initial begin
        re_b = 1'b1; en_b = 1'b0; load_b = 1'b0; mode_b = MODE_PINGPONG; lv_b = 3'd0;
        reset_a();
        check("rst_a.tc_up", {31'd0, tc_a}, 0);
        re_b = 1'b0;

        // Up count through a full wrap
        for (int k = 1; k <= 10; k++)
            step_a($sformatf("up%0d", k), 1'b1, MODE_UP, 1'b0, 4'd0, k % 8, (k % 8) == 7, (k % 8) == 0);

        // Down count from reset
        reset_a();
        mode_a = MODE_DOWN;
        #1;
        check("down.tc_at0", {31'd0, tc_a}, 1);
        step_a("down1", 1'b1, MODE_DOWN, 1'b0, 4'd0, 7, 1'b0, 1'b1);
        step_a("down2", 1'b1, MODE_DOWN, 1'b0, 4'd0, 6, 1'b0, 1'b0);
        step_a("down3", 1'b1, MODE_DOWN, 1'b0, 4'd0, 5, 1'b0, 1'b0);

        // Ping-pong on the MODULO=5 counter
        check("pp.rst_count", {29'd0, count_b}, 0);
        for (int k = 0; k < 11; k++)
            step_b($sformatf("pp%0d", k + 1), 1'b1, MODE_PINGPONG, pp_cnt[k], pp_tc[k], pp_wrap[k]);

        // Load clamps and wins over en
        reset_a();
        step_a("load_clamp", 1'b1, MODE_UP, 1'b1, 4'd12, 7, 1'b1, 1'b0);
        step_a("after_clamp", 1'b1, MODE_UP, 1'b0, 4'd0, 0, 1'b0, 1'b1);
        step_a("load_pp_max", 1'b1, MODE_PINGPONG, 1'b1, 4'd7, 7, 1'b0, 1'b0);
        step_a("pp_from_max", 1'b1, MODE_PINGPONG, 1'b0, 4'd0, 6, 1'b0, 1'b0);
        step_a("load_3", 1'b0, MODE_UP, 1'b1, 4'd3, 3, 1'b0, 1'b0);

        // Enable gating and hold mode
        reset_a();
        step_a("en1", 1'b1, MODE_UP, 1'b0, 4'd0, 1, 1'b0, 1'b0);
        step_a("en0a", 1'b0, MODE_UP, 1'b0, 4'd0, 1, 1'b0, 1'b0);
        step_a("en0b", 1'b0, MODE_UP, 1'b0, 4'd0, 1, 1'b0, 1'b0);
        step_a("en1b", 1'b1, MODE_UP, 1'b0, 4'd0, 2, 1'b0, 1'b0);
        step_a("hold1", 1'b1, MODE_HOLD, 1'b0, 4'd0, 2, 1'b0, 1'b0);
        step_a("hold2", 1'b1, MODE_HOLD, 1'b0, 4'd0, 2, 1'b0, 1'b0);

        // Asynchronous reset between edges
        for (int k = 3; k <= 5; k++)
            step_a($sformatf("pre_async%0d", k), 1'b1, MODE_UP, 1'b0, 4'd0, k, 1'b0, 1'b0);
        en_a = 1'b0;
        #2 re_a = 1'b1;
        #1;
        check("async.count", {28'd0, count_a}, 0);
        check("async.wrap",  {31'd0, wrap_a},  0);
`ifdef GRAY_OUT_EN
        check("async.gray",  {28'd0, gray_a},  0);
`endif
        re_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step_a($sformatf("gray_up%0d", k), 1'b1, MODE_UP, 1'b0, 4'd0, k, k == 7, 1'b0);
`ifdef GRAY_OUT_EN
            check($sformatf("gray%0d", k), {28'd0, gray_a}, gray_tab[k]);
`endif
        end
        step_a("wrap_then_rst", 1'b0, MODE_UP, 1'b1, 4'd7, 7, 1'b1, 1'b0);
        step_a("wrap_pulse", 1'b1, MODE_UP, 1'b0, 4'd0, 0, 1'b0, 1'b1);
        en_a = 1'b0;
        #2 re_a = 1'b1;
        #1;
        check("async_wrap.wrap", {31'd0, wrap_a}, 0);
        re_a = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
